br_cmp_sched: RTL

- Shared branch-compare scheduler. Arbitrates one N-bit compare datapath (subtract-based less/equal) between two requesters: req0 is the branch unit and req1 is the ALU SLT/SLTU path.
- Latches the operands, sequences the compare over a fixed multi-cycle FSM and returns a registered result through a valid/ready response channel.
- Sits between the decode/execute stage and the compare datapath.

---
 rtl/br_cmp_pkg.sv | 25 ++
 rtl/br_cmp_core.sv | 25 ++
 rtl/br_cmp_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/br_cmp_pkg.sv
// Shared types for the branch-compare scheduler: funct3 encodings, FSM states
// and the signedness helper.
package br_cmp_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESP
  } state_e;

  // Only BLTU/BGEU are unsigned; illegal encodings fall back to signed.
  function automatic logic is_signed(input logic [2:0] f3);
    return !(f3[2] && f3[1]);
  endfunction

endpackage

// File: rtl/br_cmp_core.sv
// Combinational subtract-based compare: less (signed or unsigned) and equal.
module br_cmp_core #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  input  logic         sgn,
  output logic         less,
  output logic         equal
);

  logic [N:0] sub;
  logic       borrow;

  always_comb begin
    sub    = {1'b0, rs1} - {1'b0, rs2};
    borrow = sub[N];
    equal  = (sub[N-1:0] == '0);
    if (sgn && (rs1[N-1] != rs2[N-1]))
      less = rs1[N-1];
    else
      less = borrow;
  end

endmodule

// File: rtl/br_cmp_sched.sv
// Two-requester scheduler for a shared branch-compare datapath.
// Optional statistics counters are enabled by defining BR_CMP_STATS_EN.
module br_cmp_sched
  import br_cmp_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [2:0]   req0_funct3_i,
  input  logic [N-1:0] req0_rs1_i,
  input  logic [N-1:0] req0_rs2_i,
  input  logic [2:0]   req1_funct3_i,
  input  logic [N-1:0] req1_rs1_i,
  input  logic [N-1:0] req1_rs2_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic         resp_id_o,
  output logic         resp_taken_o,
  output logic         resp_less_o,
  output logic         resp_equal_o,
  output logic         resp_err_o
`ifdef BR_CMP_STATS_EN
  ,
  output logic [31:0]  stat_total_o,
  output logic [31:0]  stat_taken_o
`endif
);

  state_e         state, state_nxt;
  logic           ptr;
  logic [2:0]     f3;
  logic [N-1:0]   opa, opb;
  logic           id;
  logic [1:0]     grant;
  logic           less, equal, taken, err;

  br_cmp_core #(.N(N)) u_core (
    .rs1   (opa),
    .rs2   (opb),
    .sgn   (is_signed(f3)),
    .less  (less),
    .equal (equal)
  );

  always_comb begin
    grant     = '0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // Grant is gated by reset so the accept strobe reads 0 during reset.
        if (!rst_i) begin
          case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
          endcase
        end
        if (grant != '0) state_nxt = S_CMP;
      end
      S_CMP:   state_nxt = S_RESP;
      S_RESP:  if (resp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready_o = grant;

  always_comb begin
    taken = 1'b0;
    err   = 1'b0;
    case (f3)
      F3_BEQ:           taken = equal;
      F3_BNE:           taken = !equal;
      F3_BLT, F3_BLTU:  taken = less;
      F3_BGE, F3_BGEU:  taken = !less;
      default:          err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      ptr          <= RR_INIT;
      f3           <= '0;
      opa          <= '0;
      opb          <= '0;
      id           <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= 1'b0;
      resp_taken_o <= 1'b0;
      resp_less_o  <= 1'b0;
      resp_equal_o <= 1'b0;
      resp_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant != '0) begin
        id  <= grant[1];
        f3  <= grant[1] ? req1_funct3_i : req0_funct3_i;
        opa <= grant[1] ? req1_rs1_i    : req0_rs1_i;
        opb <= grant[1] ? req1_rs2_i    : req0_rs2_i;
      end
      if (state == S_CMP) begin
        resp_valid_o <= 1'b1;
        resp_id_o    <= id;
        resp_taken_o <= taken;
        resp_less_o  <= less;
        resp_equal_o <= equal;
        resp_err_o   <= err;
      end
      if (state == S_RESP && resp_ready_i) begin
        resp_valid_o <= 1'b0;
        ptr          <= !resp_id_o;
      end
    end
  end

`ifdef BR_CMP_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_total_o <= '0;
      stat_taken_o <= '0;
    end else if (resp_valid_o && resp_ready_i) begin
      stat_total_o <= stat_total_o + 32'd1;
      if (resp_taken_o) stat_taken_o <= stat_taken_o + 32'd1;
    end
  end
`endif

endmodule
